// File: rtl/ksa_pkg.sv
// Shared constants and state encoding for the multi-precision Kogge-Stone sequencer.
package ksa_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ksa_mp_state_t;

endpackage

// File: rtl/ksa_slice_16.sv
// 16-bit Kogge-Stone slice with a true carry-in/carry-out, built from two chained
// 8-bit prefix adders so the sequencer can ripple a carry between slices.
module Kogge_Stone_Adder_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] p0;
  logic [7:0] g0;
  logic [7:0] g1;
  logic [7:0] p1;
  logic [7:0] g2;
  logic [7:0] p2;
  logic [7:0] g3;
  logic [7:0] carries;

  assign p0 = a ^ b;

  // Folding cin into bit 0's generate makes every prefix group include it.
  always_comb begin
    g0 = a & b;
    g0[0] = (a[0] & b[0]) | (p0[0] & cin);
  end

  always_comb begin
    g1 = g0;
    p1 = p0;
    for (int i = 1; i < 8; i++) begin
      g1[i] = g0[i] | (p0[i] & g0[i-1]);
      p1[i] = p0[i] & p0[i-1];
    end
  end

  always_comb begin
    g2 = g1;
    p2 = p1;
    for (int i = 2; i < 8; i++) begin
      g2[i] = g1[i] | (p1[i] & g1[i-2]);
      p2[i] = p1[i] & p1[i-2];
    end
  end

  always_comb begin
    g3 = g2;
    for (int i = 4; i < 8; i++) begin
      g3[i] = g2[i] | (p2[i] & g2[i-4]);
    end
  end

  assign carries = {g3[6:0], cin};
  assign sum     = p0 ^ carries;
  assign cout    = g3[7];

endmodule

module ksa_slice_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic c_mid;

  Kogge_Stone_Adder_8 u_lo (
    .a    (a[7:0]),
    .b    (b[7:0]),
    .cin  (cin),
    .sum  (sum[7:0]),
    .cout (c_mid)
  );

  Kogge_Stone_Adder_8 u_hi (
    .a    (a[15:8]),
    .b    (b[15:8]),
    .cin  (c_mid),
    .sum  (sum[15:8]),
    .cout (cout)
  );

endmodule

// File: rtl/ksa_mp_sequencer.sv
// Multi-precision add/subtract: one 16-bit slice per clock, LSB first, carry held in a flop.
// Optional zero-result output is enabled with `define KSA_MP_ZERO_FLAG_EN.
module ksa_mp_sequencer
  import ksa_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       op_sub,
  input  logic [WORDS*SLICE_W-1:0]   a,
  input  logic [WORDS*SLICE_W-1:0]   b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORDS*SLICE_W-1:0]   sum,
  output logic                       carry_out,
  output logic                       overflow
`ifdef KSA_MP_ZERO_FLAG_EN
  ,output logic                      zero
`endif
);

  localparam int W  = WORDS * SLICE_W;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds valid (and data) until it sees ready. in_ready is high only in
  // IDLE, out_valid only in DONE; the result stays stable until out_ready.

  ksa_mp_state_t state;
  ksa_mp_state_t state_nxt;

  logic [CW-1:0]      cnt;
  logic               carry_q;
  logic               op_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sum_q;
  logic               carry_out_q;
  logic               ovf_q;

  logic [31:0]        base;
  logic [SLICE_W-1:0] a_s;
  logic [SLICE_W-1:0] b_s;
  logic [SLICE_W-1:0] s_s;
  logic               c_s;
  logic               last;

  assign base = 32'(cnt) * SLICE_W;
  assign a_s  = a_q[base +: SLICE_W];
  assign b_s  = b_q[base +: SLICE_W] ^ {SLICE_W{op_q}};
  assign last = (cnt == CW'(WORDS - 1));

  ksa_slice_16 u_slice (
    .a    (a_s),
    .b    (b_s),
    .cin  (carry_q),
    .sum  (s_s),
    .cout (c_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      carry_q     <= 1'b0;
      op_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op_sub;
            carry_q <= op_sub;
            cnt     <= '0;
          end
        end
        RUN: begin
          sum_q[base +: SLICE_W] <= s_s;
          carry_q                <= c_s;
          if (last) begin
            carry_out_q <= c_s;
            // a_s/b_s hold the top slice here, so their bit 15 is the operand MSB.
            ovf_q       <= (a_s[SLICE_W-1] == b_s[SLICE_W-1]) &&
                           (s_s[SLICE_W-1] != a_s[SLICE_W-1]);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef KSA_MP_ZERO_FLAG_EN
  logic nonzero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nonzero_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      nonzero_q <= 1'b0;
    end else if (state == RUN) begin
      nonzero_q <= nonzero_q | (|s_s);
    end
  end

  assign zero = out_valid & ~nonzero_q;
`endif

  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = ovf_q;

endmodule
